// File: rtl/ascii_digit_streamer_pkg.sv
// Shared types and constants for the ASCII digit streamer.
package ascii_digit_streamer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    EMIT,
    DONE
  } state_e;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // Largest number that fits in the given count of decimal digits.
  function automatic int max_display(input int digits);
    int m;
    m = 1;
    for (int i = 0; i < digits; i++) m = m * 10;
    return m - 1;
  endfunction

endpackage

// File: rtl/ascii_digit_streamer_if.sv
// Control and character-stream signals between a producer of values and the streamer.
interface ascii_digit_streamer_if #(
  parameter int VALUE_WIDTH = 10
) ();

  logic                   start;
  logic [VALUE_WIDTH-1:0] value;
  logic                   busy;
  logic [7:0]             charData;
  logic                   charValid;
  logic                   charReady;
  logic                   done;

  modport master (
    output start, value, charReady,
    input  busy, charData, charValid, done
  );

  modport slave (
    input  start, value, charReady,
    output busy, charData, charValid, done
  );

endinterface

// File: rtl/bcdToASCII.sv
// Maps each packed BCD nibble to its ASCII digit; all bytes read zero when disabled.
module bcdToASCII
  import ascii_digit_streamer_pkg::*;
#(
  parameter int BCD_NUMBER_LENGTH = 3
) (
  input  logic [4*BCD_NUMBER_LENGTH-1:0] bcdNumber,
  input  logic                           asciiEnable,
  output logic [8*BCD_NUMBER_LENGTH-1:0] asciiNumber
);

  always_comb begin
    asciiNumber = '0;
    if (asciiEnable) begin
      for (int i = 0; i < BCD_NUMBER_LENGTH; i++) begin
        asciiNumber[i*8 +: 8] = ASCII_ZERO + {4'h0, bcdNumber[i*4 +: 4]};
      end
    end
  end

endmodule

// File: rtl/ascii_digit_streamer.sv
// Converts a binary value to decimal with double dabble, then streams it
// most significant digit first as ASCII over a valid/ready handshake.
module ascii_digit_streamer
  import ascii_digit_streamer_pkg::*;
#(
  parameter int DIGITS        = 3,
  parameter int VALUE_WIDTH   = 10,
  parameter int BLANK_LEADING = 1
) (
  input logic                  clk,
  input logic                  reset,
  ascii_digit_streamer_if.slave bus
);

  localparam int BCD_W     = 4 * DIGITS;
  localparam int IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W     = $clog2(VALUE_WIDTH + 1);
  localparam int MAX_VALUE = max_display(DIGITS);

  state_e                 state_q, state_d;
  logic [VALUE_WIDTH-1:0] shift_q, shift_d;
  logic [BCD_W-1:0]       bcd_q, bcd_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;

  logic [BCD_W-1:0]       bcd_adj;
  logic [63:0]            value_ext;
  logic [8*DIGITS-1:0]    ascii_num;
  logic [7:0]             char_sel;
  logic                   blank;

  assign value_ext = 64'(bus.value);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    bcd_adj = bcd_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shift_d = (value_ext > 64'(MAX_VALUE)) ? VALUE_WIDTH'(MAX_VALUE) : bus.value;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        // Add-3 correction before each shift keeps every nibble a legal BCD digit.
        for (int i = 0; i < DIGITS; i++) begin
          if (bcd_adj[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_adj[i*4 +: 4] + 4'd3;
        end
        bcd_d   = BCD_W'({bcd_adj, shift_q[VALUE_WIDTH-1]});
        shift_d = shift_q << 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(VALUE_WIDTH - 1)) begin
          idx_d   = IDX_W'(DIGITS - 1);
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (bus.charReady) begin
          if (idx_q == '0) state_d = DONE;
          else             idx_d   = idx_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  bcdToASCII #(
    .BCD_NUMBER_LENGTH(DIGITS)
  ) u_bcd_to_ascii (
    .bcdNumber  (bcd_q),
    .asciiEnable(state_q == EMIT),
    .asciiNumber(ascii_num)
  );

  // A digit is blanked only if it and every more significant digit are zero.
  always_comb begin
    blank = (BLANK_LEADING != 0) && (idx_q != '0);
    for (int j = 0; j < DIGITS; j++) begin
      if ((j >= int'(idx_q)) && (bcd_q[j*4 +: 4] != 4'd0)) blank = 1'b0;
    end
    char_sel = ascii_num[int'(idx_q)*8 +: 8];
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.charValid = (state_q == EMIT);
  assign bus.done      = (state_q == DONE);
  assign bus.charData  = (state_q == EMIT) ? (blank ? ASCII_SPACE : char_sel) : 8'h00;

endmodule

// File: doc/ascii_digit_streamer.md
ASCII_DIGIT_STREAMER -- requirements
Module: ascii_digit_streamer

Interface
REQ-001 Parameter DIGITS, default 3, number of decimal digits emitted per conversion.
REQ-002 Parameter VALUE_WIDTH, default 10, width of the binary input value.
REQ-003 Parameter BLANK_LEADING, default 1, replaces leading zeros with ASCII space when 1.
REQ-004 Port clk  input  1  single clock; all logic on the rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port start  input  1  request to convert and stream value; sampled only in IDLE.
REQ-007 Port value  input  VALUE_WIDTH  unsigned binary number to display.
REQ-008 Port busy  output  1  high in every state except IDLE.
REQ-009 Port charData  output  8  ASCII character, most significant digit first.
REQ-010 Port charValid  output  1  charData holds a valid character.
REQ-011 Port charReady  input  1  consumer accepts charData when charValid and charReady are high on the same edge.
REQ-012 Port done  output  1  one-cycle pulse after the last character is accepted.

Function
REQ-013 The state machine SHALL have the states IDLE, CONVERT, EMIT and DONE.
REQ-014 In IDLE with start=1, the block SHALL capture value, clear the BCD register and enter CONVERT.
REQ-015 A captured value above 10^DIGITS-1 SHALL clamp to 10^DIGITS-1 (999 for the defaults).
REQ-016 CONVERT SHALL run shift-add-3 (double dabble) for exactly VALUE_WIDTH cycles, one bit per cycle, MSB first, then enter EMIT.
REQ-017 charValid SHALL first be high VALUE_WIDTH+1 edges after the start edge (11 for the defaults).
REQ-018 In EMIT, the digit index SHALL start at DIGITS-1 and charData SHALL be the ASCII of BCD nibble[index], 0x30+nibble.
REQ-019 When BLANK_LEADING=1, every zero digit above the first nonzero digit SHALL emit 0x20, and the least significant digit SHALL never be blanked.
REQ-020 charData and charValid SHALL stay stable while charValid=1 and charReady=0.
REQ-021 On accept, the index SHALL decrement; accepting index 0 SHALL enter DONE with charValid=0 on the next cycle.
REQ-022 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-023 start SHALL be ignored while busy=1, and a new start SHALL be accepted in the cycle after DONE (IDLE).
REQ-024 charReady SHALL be ignored while charValid=0.

Reset
REQ-025 With reset=1 at an edge, the state SHALL become IDLE and busy, charValid, done and charData SHALL become 0 (charData=8'h00), from any state including mid-CONVERT or mid-EMIT.
REQ-026 Reset SHALL take priority over start on the same edge.
REQ-027 After reset deasserts, the block SHALL accept start on the first following edge.

Structure
REQ-028 A shared package SHALL hold the state enumeration and the constants ASCII_ZERO=8'h30 and ASCII_SPACE=8'h20.
REQ-029 The block SHALL contain exactly one sub-module, the existing bcdToASCII converter, instantiated with BCD_NUMBER_LENGTH=DIGITS and asciiEnable driven high in EMIT.
REQ-030 The block SHALL select charData from that converter's output slice for the current index, or ASCII_SPACE when blanked.

Verification
REQ-031 Stimulus value=123 with charReady held at 1 -> 0x31, 0x32, 0x33 on consecutive cycles, the first at start+11, then done one cycle after the last character.
REQ-032 Stimulus value=0 with BLANK_LEADING=1 -> 0x20, 0x20, 0x30; value=7 with BLANK_LEADING=0 -> 0x30, 0x30, 0x37.
REQ-033 Stimulus value=1023 -> clamped output 0x39, 0x39, 0x39.
REQ-034 Stimulus value=405 with charReady=0 for 5 cycles on the first character -> 0x34 held stable for 5 cycles, then 0x30, 0x35, and no character lost or duplicated.
REQ-035 Stimulus: start pulses during CONVERT and EMIT -> ignored and the output is unchanged; a start in the cycle after done -> a new conversion.
REQ-036 Stimulus: reset during EMIT after one accepted character -> next edge IDLE, all outputs 0, and a subsequent value=56 streams 0x20, 0x35, 0x36.
